// File: rtl/fetch_ctrl.sv
// Program counter and fetch control in front of a 256-entry synchronous
// instruction memory: start/halt/stall handling, LUT branch redirects, inst_valid.
module fetch_ctrl #(
    parameter int PC_W   = 8,
    parameter int LUT_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [LUT_AW-1:0] target_idx,
    input  logic              halt_req,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_waddr,
    input  logic [PC_W-1:0]   lut_wdata,
    output logic [PC_W-1:0]   pc,
    output logic              inst_valid,
    output logic              running,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state;
    logic              fetch_q;
    logic [PC_W-1:0]   lut [0:(1<<LUT_AW)-1];
    logic [PC_W-1:0]   target;

    // Combinational read sees the pre-write contents on a same-index write.
    assign target = lut[target_idx];

    always_ff @(posedge clk) begin
        if (lut_we) begin
            lut[lut_waddr] <= lut_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= '0;
            fetch_q    <= 1'b0;
            inst_valid <= 1'b0;
            running    <= 1'b0;
            done       <= 1'b0;
        end else begin
            inst_valid <= 1'b0;
            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        state   <= RUN;
                        pc      <= '0;
                        fetch_q <= 1'b1;
                        running <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                RUN: begin
                    // Halt or redirect kills the instruction already in flight.
                    inst_valid <= fetch_q && !halt_req && !branch_taken;
                    if (halt_req) begin
                        state   <= HALTED;
                        fetch_q <= 1'b0;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else if (branch_taken) begin
                        // The target fetch itself is committed: one-bubble penalty.
                        pc      <= target;
                        fetch_q <= 1'b1;
                    end else if (stall) begin
                        fetch_q <= 1'b0;
                    end else begin
                        pc      <= pc + PC_W'(1);
                        fetch_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    fetch_q <= 1'b0;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with constant expectations, then
// random stimulus compared against a fetch-stream reference model.
module tb_fetch_ctrl;

    logic       clk;
    logic       reset, start, stall, branch_taken, halt_req, lut_we;
    logic [4:0] target_idx, lut_waddr;
    logic [7:0] lut_wdata;
    logic [7:0] pc;
    logic       inst_valid, running, done;
    logic [7:0] addr_q;

    int errors = 0;
    int checks = 0;

    // Reference model: which address is presented, whether it is a real fetch,
    // and which address the valid instruction next cycle will come from.
    logic [7:0] m_pc, m_addr;
    bit         m_valid, m_run, m_done, m_commit;
    logic [7:0] m_lut [32];

    fetch_ctrl #(.PC_W(8), .LUT_AW(5)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .branch_taken(branch_taken), .target_idx(target_idx),
        .halt_req(halt_req), .lut_we(lut_we), .lut_waddr(lut_waddr),
        .lut_wdata(lut_wdata), .pc(pc), .inst_valid(inst_valid),
        .running(running), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the instruction memory: the address that produced this cycle's inst.
    always_ff @(posedge clk) addr_q <= pc;

    task automatic model_step();
        logic [7:0] tgt;
        tgt = m_lut[target_idx];
        if (reset) begin
            m_pc = 8'd0; m_valid = 0; m_run = 0; m_done = 0; m_commit = 0;
        end else begin
            m_valid = m_run && m_commit && !halt_req && !branch_taken;
            m_addr  = m_pc;
            if (!m_run) begin
                if (start) begin
                    m_pc = 8'd0; m_run = 1; m_done = 0; m_commit = 1;
                end
            end else if (halt_req) begin
                m_run = 0; m_done = 1; m_commit = 0;
            end else if (branch_taken) begin
                m_pc = tgt; m_commit = 1;
            end else if (stall) begin
                m_commit = 0;
            end else begin
                m_pc = 8'((int'(m_pc) + 1) % 256); m_commit = 1;
            end
        end
        if (lut_we) m_lut[lut_waddr] = lut_wdata;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        reset = 0; start = 0; stall = 0; branch_taken = 0; halt_req = 0;
        lut_we = 0; target_idx = '0; lut_waddr = '0; lut_wdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1; tick(); tick(); reset = 0;
    endtask

    task automatic lut_write(input logic [4:0] idx, input logic [7:0] data);
        lut_we = 1; lut_waddr = idx; lut_wdata = data; tick(); lut_we = 0;
    endtask

    task automatic do_start();
        start = 1; tick(); start = 0;
    endtask

    task automatic run_to_pc(input logic [7:0] want);
        int n = 0;
        while (pc !== want && n < 300) begin tick(); n++; end
        checks++;
        if (pc !== want) begin
            errors++;
            $display("FAIL run_to_pc: pc=%0h never reached %0h", pc, want);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1; stall = 1; branch_taken = 1; tick(); tick();
        checks++;
        if (pc !== 8'd0 || inst_valid !== 1'b0 || running !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pc=%0h v=%b run=%b done=%b, want 0 0 0 0",
                     pc, inst_valid, running, done);
        end
        reset = 0; tick(); tick();
        checks++;
        if (pc !== 8'd0 || inst_valid !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores: pc=%0h v=%b run=%b, want 0 0 0", pc, inst_valid, running);
        end
        clear_inputs();
    endtask

    task automatic test_run_wrap();
        logic [7:0] exp_pc, exp_addr;
        do_reset();
        do_start();
        checks++;
        if (pc !== 8'd0 || running !== 1'b1 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_entry: pc=%0h run=%b v=%b, want 0 1 0", pc, running, inst_valid);
        end
        for (int i = 1; i <= 260; i++) begin
            tick();
            exp_pc = i[7:0];
            exp_addr = 8'(i - 1);
            checks++;
            if (pc !== exp_pc || inst_valid !== 1'b1 || addr_q !== exp_addr) begin
                errors++;
                $display("FAIL seq_step%0d: pc=%0h v=%b addr=%0h, want %0h 1 %0h",
                         i, pc, inst_valid, addr_q, exp_pc, exp_addr);
            end
            if (i == 256) begin
                checks++;
                if (pc !== 8'd0) begin
                    errors++;
                    $display("FAIL wrap: pc=%0h, want 0", pc);
                end
            end
        end
    endtask

    task automatic test_branch();
        do_reset();
        lut_write(5'd3, 8'h40);
        do_start();
        run_to_pc(8'd10);
        branch_taken = 1; target_idx = 5'd3; tick(); branch_taken = 0;
        checks++;
        if (pc !== 8'h40 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL branch_redirect: pc=%0h v=%b, want 40 0", pc, inst_valid);
        end
        tick();
        checks++;
        if (inst_valid !== 1'b1 || addr_q !== 8'h40 || pc !== 8'h41) begin
            errors++;
            $display("FAIL branch_target_valid: v=%b addr=%0h pc=%0h, want 1 40 41",
                     inst_valid, addr_q, pc);
        end
    endtask

    task automatic test_stall();
        do_reset();
        do_start();
        run_to_pc(8'd5);
        stall = 1;
        tick();
        checks++;
        if (pc !== 8'd5 || inst_valid !== 1'b1 || addr_q !== 8'd5) begin
            errors++;
            $display("FAIL stall_first: pc=%0h v=%b addr=%0h, want 5 1 5", pc, inst_valid, addr_q);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (pc !== 8'd5 || inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: pc=%0h v=%b, want 5 0", k, pc, inst_valid);
            end
        end
        stall = 0;
        tick();
        checks++;
        if (pc !== 8'd6 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: pc=%0h v=%b, want 6 0", pc, inst_valid);
        end
        tick();
        checks++;
        if (pc !== 8'd7 || inst_valid !== 1'b1 || addr_q !== 8'd6) begin
            errors++;
            $display("FAIL stall_resume: pc=%0h v=%b addr=%0h, want 7 1 6", pc, inst_valid, addr_q);
        end
    endtask

    task automatic test_halt_branch();
        do_reset();
        lut_write(5'd1, 8'h90);
        do_start();
        tick(); tick(); tick();
        halt_req = 1; branch_taken = 1; target_idx = 5'd1; tick();
        halt_req = 0;
        checks++;
        if (pc !== 8'd3 || done !== 1'b1 || running !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_wins: pc=%0h done=%b run=%b v=%b, want 3 1 0 0",
                     pc, done, running, inst_valid);
        end
        stall = 1; tick(); tick();
        checks++;
        if (pc !== 8'd3 || done !== 1'b1 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL halted_frozen: pc=%0h done=%b v=%b, want 3 1 0", pc, done, inst_valid);
        end
        clear_inputs();
        do_start();
        checks++;
        if (pc !== 8'd0 || done !== 1'b0 || running !== 1'b1) begin
            errors++;
            $display("FAIL restart: pc=%0h done=%b run=%b, want 0 0 1", pc, done, running);
        end
        tick();
        checks++;
        if (inst_valid !== 1'b1 || addr_q !== 8'd0) begin
            errors++;
            $display("FAIL restart_valid: v=%b addr=%0h, want 1 0", inst_valid, addr_q);
        end
    endtask

    task automatic test_lut_bypass();
        do_reset();
        lut_write(5'd7, 8'h20);
        do_start();
        tick(); tick();
        lut_we = 1; lut_waddr = 5'd7; lut_wdata = 8'h80;
        branch_taken = 1; target_idx = 5'd7;
        tick();
        lut_we = 0;
        checks++;
        if (pc !== 8'h20) begin
            errors++;
            $display("FAIL lut_old_value: pc=%0h, want 20", pc);
        end
        tick();
        branch_taken = 0;
        checks++;
        if (pc !== 8'h80) begin
            errors++;
            $display("FAIL lut_new_value: pc=%0h, want 80", pc);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        do_start();
        tick(); tick(); tick(); tick();
        stall = 1; reset = 1; tick(); reset = 0;
        checks++;
        if (pc !== 8'd0 || inst_valid !== 1'b0 || running !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: pc=%0h v=%b run=%b done=%b, want 0 0 0 0",
                     pc, inst_valid, running, done);
        end
        branch_taken = 1; target_idx = 5'd7; tick(); tick(); tick();
        checks++;
        if (pc !== 8'd0 || running !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_ignore: pc=%0h run=%b v=%b, want 0 0 0", pc, running, inst_valid);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 32; i++) lut_write(5'(i), 8'($urandom));
        do_start();
        for (int c = 0; c < 800; c++) begin
            reset        = ($urandom % 200) == 0;
            start        = ($urandom % 12) == 0;
            stall        = ($urandom % 4) == 0;
            branch_taken = ($urandom % 7) == 0;
            halt_req     = ($urandom % 50) == 0;
            target_idx   = 5'($urandom);
            lut_we       = ($urandom % 5) == 0;
            lut_waddr    = 5'($urandom);
            lut_wdata    = 8'($urandom);
            tick();
            checks++;
            if (pc !== m_pc || inst_valid !== m_valid || running !== m_run || done !== m_done) begin
                errors++;
                $display("FAIL rand_cycle%0d: pc=%0h v=%b run=%b done=%b, want %0h %b %b %b",
                         c, pc, inst_valid, running, done, m_pc, m_valid, m_run, m_done);
            end
            if (m_valid) begin
                checks++;
                if (addr_q !== m_addr) begin
                    errors++;
                    $display("FAIL rand_fetch%0d: addr=%0h, want %0h", c, addr_q, m_addr);
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        m_pc = 8'd0; m_addr = 8'd0; m_valid = 0; m_run = 0; m_done = 0; m_commit = 0;
        test_reset();
        test_run_wrap();
        test_branch();
        test_stall();
        test_halt_branch();
        test_lut_bypass();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
